// File: rtl/pipe_pkg.sv
// Shared control-payload layout for the pipeline stage and its skid buffer.
package pipe_pkg;

  localparam int CTRL_W_DEF   = 8;
  localparam int RD_LSB       = 0;
  localparam int RD_W         = 5;
  localparam int MEMTOREG_BIT = 5;
  localparam int REGWRITE_BIT = 6;
  localparam int IS_JAL_BIT   = 7;

  typedef struct packed {
    logic           is_jal;
    logic           reg_write;
    logic           mem_to_reg;
    logic [RD_W-1:0] rd;
  } ctrl_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer holding a data/control beat while the main register is stalled.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (push) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      ctrl_reg  <= in_ctrl;
    end else if (pop) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush, gated control and saturating stall counter.
// Optional 1-entry skid buffer enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [CNT_W-1:0]  stall_reg;
  logic              accept;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              load_main;
  logic              skid_push;
  logic              skid_pop;

  // Main register can take a beat when empty or draining this cycle.
  assign load_main = !valid_reg || out_ready;
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && !skid_valid;
  assign skid_push = accept && !load_main;
  assign skid_pop  = skid_valid && load_main;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (skid_push),
    .pop     (skid_pop),
    .in_data (in_data),
    .in_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (skid_pop) begin
      valid_reg <= 1'b1;
      data_reg  <= skid_data;
      ctrl_reg  <= skid_ctrl;
    end else if (accept && load_main) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      ctrl_reg  <= in_ctrl;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end
`else
  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // An accept in the same cycle as a drain replaces the held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      ctrl_reg  <= in_ctrl;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (!flush && valid_reg && !out_ready && stall_reg != {CNT_W{1'b1}}) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign stall_cnt = stall_reg;

  // Bubbles carry all-zero control so RegWrite can never leak downstream.
  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
    assign out_ctrl[gi] = ctrl_reg[gi] & valid_reg;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning width of the datapath payload (3 x 32-bit words).
REQ-002 SHALL have parameter CTRL_W, default 8, meaning width of the control payload (rd[4:0], MemtoReg, RegWrite, is_jal).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the stall counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream holds a valid beat.
REQ-007 SHALL have port in_ready, output, 1 bit: stage accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits: upstream datapath payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W bits: upstream control payload.
REQ-010 SHALL have port flush, input, 1 bit: discard all held beats.
REQ-011 SHALL have port out_valid, output, 1 bit: stage holds a valid beat.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-013 SHALL have port out_data, output, DATA_W bits: held datapath payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W bits: held control payload, gated.
REQ-015 SHALL have port stall_cnt, output, CNT_W bits: count of stalled cycles.

Function
REQ-016 SHALL complete an input transfer on a rising edge only when in_valid and in_ready are both 1, and an output transfer only when out_valid and out_ready are both 1.
REQ-017 SHALL present an accepted beat on out_* exactly 1 cycle after acceptance.
REQ-018 SHALL drive out_ctrl to all-zero whenever out_valid=0, so a bubble never asserts RegWrite.
REQ-019 SHALL keep out_data at its last captured value while out_valid=0; out_data is ungated.
REQ-020 SHALL hold out_data and out_ctrl stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, without skid, drive in_ready = !out_valid || out_ready, giving full throughput with back-to-back beats.
REQ-022 SHALL give simultaneous accept and drain in one cycle a replace: the new beat is held next cycle and out_valid stays 1.
REQ-023 SHALL, on flush=1, clear all valid state at the next edge; flush has priority over a same-cycle input transfer, and that beat is dropped.
REQ-024 SHALL still complete an output transfer in the flush cycle; flush only clears held state.
REQ-025 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1 with no wrap, and leave it unchanged on flush.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, set out_valid=0, out_data=0, internal ctrl=0, stall_cnt=0 and skid valid/data=0.
REQ-027 SHALL give rst priority over flush and over any handshake, and drop a beat in flight mid-operation.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset is released.

Configuration
REQ-029 SHALL, with macro PIPE_STAGE_SKID_EN defined, add a 1-entry skid buffer and drive in_ready = !skid_valid from a register, with no combinational path from out_ready.
REQ-030 SHALL, with the skid, capture an incoming beat into the skid when out_valid=1 and out_ready=0; the skid moves to the main register on the next output transfer; order is preserved and latency stays 1 cycle when not stalled.
REQ-031 SHALL have flush clear the skid valid as well as the main valid.
REQ-032 SHALL, without the macro, implement no skid logic and use the in_ready of REQ-021.

Structure
REQ-033 SHALL place the CTRL_W default and the control bit positions (RD_LSB=0, MEMTOREG_BIT=5, REGWRITE_BIT=6, IS_JAL_BIT=7) in shared package pipe_pkg.
REQ-034 SHALL implement the skid buffer as sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-035 SHALL cover: after reset, in_valid=1, in_ctrl=8'h65, in_data=96'h1, out_ready=1 -> next cycle out_valid=1, out_ctrl=8'h65; in_valid=0 afterwards -> out_ctrl=8'h00.
REQ-036 SHALL cover: 10 back-to-back beats with out_ready=1 -> 10 outputs on consecutive cycles, in order, 1-cycle latency.
REQ-037 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> out_data stable and stall_cnt=5; with CNT_W=3 and 9 stalled cycles -> stall_cnt=7.
REQ-038 SHALL cover: flush and in_valid both 1 with a beat held -> next cycle out_valid=0 and out_ctrl=0; stall_cnt unchanged.
REQ-039 SHALL cover: rst=1 while out_valid=1 and the skid is full -> next cycle all outputs 0, in_ready=1.
REQ-040 SHALL cover, with PIPE_STAGE_SKID_EN: stall while 2 beats arrive -> in_ready=0 after the second; release -> both beats delivered in order, no loss or duplication.
